// File: rtl/regfile_arb_pkg.sv
// Shared constants and the writeback request record for the register-file
// writeback arbiter. Optional build macro used by the top: RF_ARB_PERF_EN.
package regfile_arb_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS   = 32;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic [XLEN-1:0]       data;
    } wb_req_t;

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Writeback request bus: one valid/ready pair plus destination and data per
// source. Writeback units use the master side, the arbiter the slave side.
interface regfile_wb_arbiter_if
    import regfile_arb_pkg::*;
#(
    parameter int NUM_REQ = 3
);
    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ-1:0]            req_ready;
    logic [NUM_REQ*REG_ADDR_W-1:0] req_rd;
    logic [NUM_REQ*XLEN-1:0]       req_data;

    modport master (
        output req_valid,
        output req_rd,
        output req_data,
        input  req_ready
    );

    modport slave (
        input  req_valid,
        input  req_rd,
        input  req_data,
        output req_ready
    );
endinterface

// File: rtl/regfile_wb_arbiter_rr.sv
// Round-robin arbiter: grants the first requester at or after the pointer,
// scanning upward with wrap. The pointer moves past the winner only when the
// advance strobe reports that the grant was actually taken.
module rr_arbiter #(
    parameter int N = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] i_req,
    input  logic         i_advance,
    output logic [N-1:0] o_grant
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0] r_ptr;
    logic [PW-1:0] w_gidx;
    logic          w_found;
    int            w_idx;

    // Priority scan starting at the pointer, wrapping N-1 -> 0.
    always_comb begin
        o_grant = '0;
        w_gidx  = '0;
        w_found = 1'b0;
        w_idx   = 0;
        for (int k = 0; k < N; k++) begin
            w_idx = int'(r_ptr) + k;
            if (w_idx >= N) begin
                w_idx = w_idx - N;
            end
            if (!w_found && i_req[w_idx]) begin
                w_found        = 1'b1;
                o_grant[w_idx] = 1'b1;
                w_gidx         = PW'(w_idx);
            end
        end
    end

    // Pointer moves to the slot after the winner on a taken grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= '0;
        end else if (i_advance && w_found) begin
            r_ptr <= (w_gidx == PW'(N-1)) ? '0 : w_gidx + 1'b1;
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Register-file writeback arbiter: shares the single write port between
// NUM_REQ sources, registers the granted write, and tracks pending
// destinations in a busy scoreboard. Define RF_ARB_PERF_EN to build the
// grant/conflict performance counters; otherwise the perf ports read zero.
module regfile_wb_arbiter
    import regfile_arb_pkg::*;
#(
    parameter int NUM_REQ = 3
) (
    input  logic                    clk,
    input  logic                    rst_n,
    regfile_wb_arbiter_if.slave     bus,
    input  logic                    i_claim_valid,
    input  logic [REG_ADDR_W-1:0]   i_claim_rd,
    output logic [REG_ADDR_W-1:0]   o_rf_rd_addr,
    output logic [XLEN-1:0]         o_rf_rd_data,
    output logic                    o_rf_reg_write,
    output logic [NUM_REGS-1:0]     o_busy_mask,
    output logic [NUM_REQ*32-1:0]   o_perf_grant_cnt,
    output logic [31:0]             o_perf_conflict_cnt
);

    logic [NUM_REQ-1:0]  w_grant;
    logic                w_xfer;
    wb_req_t             w_sel;
    wb_req_t             r_wb;
    logic                r_wr;
    logic [NUM_REGS-1:0] r_busy;
    logic [NUM_REGS-1:0] w_busy_nxt;

    rr_arbiter #(.N(NUM_REQ)) u_rr (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_req     (bus.req_valid),
        .i_advance (w_xfer),
        .o_grant   (w_grant)
    );

    // Ready is the grant itself, so a grant is always a transfer.
    assign bus.req_ready = w_grant;
    assign w_xfer        = |w_grant;

    // One-hot AND-OR select of the granted source's destination and data.
    always_comb begin
        w_sel = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_grant[i]) begin
                w_sel.rd   = w_sel.rd   | bus.req_rd[i*REG_ADDR_W +: REG_ADDR_W];
                w_sel.data = w_sel.data | bus.req_data[i*XLEN +: XLEN];
            end
        end
    end

    // Output stage: an x0 transfer is accepted but treated like no write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr <= 1'b0;
            r_wb <= '0;
        end else if (w_xfer && (w_sel.rd != '0)) begin
            r_wr <= 1'b1;
            r_wb <= w_sel;
        end else begin
            r_wr <= 1'b0;
        end
    end

    assign o_rf_reg_write = r_wr;
    assign o_rf_rd_addr   = r_wb.rd;
    assign o_rf_rd_data   = r_wb.data;

    // Scoreboard next state: commit clears, claim sets afterwards so it wins.
    always_comb begin
        w_busy_nxt = r_busy;
        if (r_wr) begin
            w_busy_nxt[r_wb.rd] = 1'b0;
        end
        if (i_claim_valid && (i_claim_rd != '0)) begin
            w_busy_nxt[i_claim_rd] = 1'b1;
        end
        w_busy_nxt[0] = 1'b0;
    end

    // Scoreboard register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy <= '0;
        end else begin
            r_busy <= w_busy_nxt;
        end
    end

    assign o_busy_mask = r_busy;

`ifdef RF_ARB_PERF_EN
    logic [31:0] r_grant_cnt [NUM_REQ];
    logic [31:0] r_conflict_cnt;
    logic        w_conflict;

    assign w_conflict = ($countones(bus.req_valid) >= 2);

    // Free-running wrapping counters of grants per source and contended cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                r_grant_cnt[i] <= '0;
            end
            r_conflict_cnt <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (w_grant[i]) begin
                    r_grant_cnt[i] <= r_grant_cnt[i] + 32'd1;
                end
            end
            if (w_conflict) begin
                r_conflict_cnt <= r_conflict_cnt + 32'd1;
            end
        end
    end

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_perf
        assign o_perf_grant_cnt[g*32 +: 32] = r_grant_cnt[g];
    end
    assign o_perf_conflict_cnt = r_conflict_cnt;
`else
    assign o_perf_grant_cnt    = '0;
    assign o_perf_conflict_cnt = '0;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: a reference model predicts grants,
// the registered write and the scoreboard; expected writes are queued when
// stimulus is driven and compared when the output stage presents them.
module tb_regfile_wb_arbiter;
    import regfile_arb_pkg::*;

    localparam int NR = 3;

    typedef struct packed {
        logic    wr;
        wb_req_t wb;
    } exp_t;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic                  claim_valid;
    logic [REG_ADDR_W-1:0] claim_rd;
    logic [REG_ADDR_W-1:0] rf_rd_addr;
    logic [XLEN-1:0]       rf_rd_data;
    logic                  rf_reg_write;
    logic [NUM_REGS-1:0]   busy_mask;
    logic [NR*32-1:0]      perf_grant_cnt;
    logic [31:0]           perf_conflict_cnt;

    regfile_wb_arbiter_if #(.NUM_REQ(NR)) bus ();

    regfile_wb_arbiter #(.NUM_REQ(NR)) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .bus                 (bus),
        .i_claim_valid       (claim_valid),
        .i_claim_rd          (claim_rd),
        .o_rf_rd_addr        (rf_rd_addr),
        .o_rf_rd_data        (rf_rd_data),
        .o_rf_reg_write      (rf_reg_write),
        .o_busy_mask         (busy_mask),
        .o_perf_grant_cnt    (perf_grant_cnt),
        .o_perf_conflict_cnt (perf_conflict_cnt)
    );

    always #5 clk = ~clk;

    int          n_chk = 0;
    int          n_err = 0;
    exp_t        exp_q[$];
    int          m_ptr;
    logic        m_wr;
    wb_req_t     m_wb;
    logic [31:0] m_busy;
    logic [31:0] m_conf;
    logic [31:0] m_gcnt [NR];

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] expv);
        n_chk++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic model_reset();
        m_ptr  = 0;
        m_wr   = 1'b0;
        m_wb   = '0;
        m_busy = '0;
        m_conf = '0;
        for (int i = 0; i < NR; i++) m_gcnt[i] = '0;
        exp_q.delete();
    endtask

    task automatic check_perf(input string tag);
        logic [NR*32-1:0] eg;
        for (int i = 0; i < NR; i++) eg[i*32 +: 32] = m_gcnt[i];
`ifdef RF_ARB_PERF_EN
        check({tag, "_grant_cnt"}, 128'(perf_grant_cnt), 128'(eg));
        check({tag, "_conflict_cnt"}, 128'(perf_conflict_cnt), 128'(m_conf));
`else
        check({tag, "_grant_cnt_off"}, 128'(perf_grant_cnt), 128'(0));
        check({tag, "_conflict_cnt_off"}, 128'(perf_conflict_cnt), 128'(0));
`endif
    endtask

    // One clock: drive at negedge, check ready, predict, check outputs after the edge.
    task automatic cyc(input logic [NR-1:0] v, input logic [NR*5-1:0] rds,
                       input logic [NR*32-1:0] dat, input logic cv, input logic [4:0] crd);
        logic [NR-1:0] g;
        int            gi;
        int            idx;
        exp_t          e;
        wb_req_t       s;
        logic [31:0]   nb;
        bus.req_valid = v;
        bus.req_rd    = rds;
        bus.req_data  = dat;
        claim_valid   = cv;
        claim_rd      = crd;
        g  = '0;
        gi = -1;
        for (int k = 0; k < NR; k++) begin
            idx = (m_ptr + k) % NR;
            if (gi < 0 && v[idx]) begin
                gi     = idx;
                g[idx] = 1'b1;
            end
        end
        #1;
        check("ready", 128'(bus.req_ready), 128'(g));
        nb = m_busy;
        if (m_wr) nb[m_wb.rd] = 1'b0;
        if (cv && crd != 5'd0) nb[crd] = 1'b1;
        e.wr = 1'b0;
        e.wb = m_wb;
        if (gi >= 0) begin
            s.rd   = rds[gi*5 +: 5];
            s.data = dat[gi*32 +: 32];
            if (s.rd != 5'd0) begin
                e.wr = 1'b1;
                e.wb = s;
            end
            m_ptr = (gi == NR-1) ? 0 : gi + 1;
            m_gcnt[gi] = m_gcnt[gi] + 32'd1;
        end
        if ($countones(v) >= 2) m_conf = m_conf + 32'd1;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        e      = exp_q.pop_front();
        m_wr   = e.wr;
        m_wb   = e.wb;
        m_busy = nb;
        check("rf_reg_write", 128'(rf_reg_write), 128'(e.wr));
        check("rf_rd_addr", 128'(rf_rd_addr), 128'(e.wb.rd));
        check("rf_rd_data", 128'(rf_rd_data), 128'(e.wb.data));
        check("busy_mask", 128'(busy_mask), 128'(nb));
        @(negedge clk);
    endtask

    initial begin
        bus.req_valid = '0;
        bus.req_rd    = '0;
        bus.req_data  = '0;
        claim_valid   = 1'b0;
        claim_rd      = '0;
        model_reset();

        #12;
        check("rst_wr", 128'(rf_reg_write), 128'(0));
        check("rst_addr", 128'(rf_rd_addr), 128'(0));
        check("rst_data", 128'(rf_rd_data), 128'(0));
        check("rst_busy", 128'(busy_mask), 128'(0));
        check("rst_ready", 128'(bus.req_ready), 128'(0));
        check_perf("rst");
        @(negedge clk);
        rst_n = 1'b1;

        // single source, then idle hold
        cyc(3'b001, {5'd0, 5'd0, 5'd5}, {32'h0, 32'h0, 32'hDEADBEEF}, 1'b0, 5'd0);
        cyc(3'b000, '0, '0, 1'b0, 5'd0);
        // lone source 2 moves the pointer back to 0
        cyc(3'b100, {5'd9, 5'd0, 5'd0}, {32'h99, 32'h0, 32'h0}, 1'b0, 5'd0);
        // full contention: expected order 0,1,2,0,1,2
        repeat (6) cyc(3'b111, {5'd3, 5'd2, 5'd1}, {32'h3333, 32'h2222, 32'h1111}, 1'b0, 5'd0);
        check_perf("contention");
        // x0 destination: accepted, no write
        cyc(3'b010, {5'd0, 5'd0, 5'd0}, {32'h0, 32'h1234, 32'h0}, 1'b0, 5'd0);
        // scoreboard: claim, write, commit clears
        cyc(3'b000, '0, '0, 1'b1, 5'd7);
        cyc(3'b001, {5'd0, 5'd0, 5'd7}, {32'h0, 32'h0, 32'h77}, 1'b0, 5'd0);
        cyc(3'b000, '0, '0, 1'b0, 5'd0);
        // claim on the commit edge keeps the bit set
        cyc(3'b000, '0, '0, 1'b1, 5'd7);
        cyc(3'b001, {5'd0, 5'd0, 5'd7}, {32'h0, 32'h0, 32'h78}, 1'b0, 5'd0);
        cyc(3'b000, '0, '0, 1'b1, 5'd7);
        // claim of x0 never sets bit 0
        cyc(3'b000, '0, '0, 1'b1, 5'd0);
        check_perf("mid");

        // reset in the middle of a registered write
        cyc(3'b010, {5'd0, 5'd4, 5'd0}, {32'h0, 32'h44, 32'h0}, 1'b1, 5'd12);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_wr", 128'(rf_reg_write), 128'(0));
        check("midrst_busy", 128'(busy_mask), 128'(0));
        check("midrst_addr", 128'(rf_rd_addr), 128'(0));
        model_reset();
        check_perf("midrst");
        @(negedge clk);
        rst_n = 1'b1;
        // pointer restarts at 0 after reset
        cyc(3'b011, {5'd0, 5'd11, 5'd10}, {32'h0, 32'hB, 32'hA}, 1'b0, 5'd0);
        cyc(3'b000, '0, '0, 1'b0, 5'd0);
        check_perf("end");

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
